// File: rtl/idu_pipe.sv
// idu_pipe: registered RV32I/RV64I decode stage. Each accepted instruction is decoded
// on entry and held in a DEPTH-entry valid/ready queue until issue pops it.
module idu_pipe #(
    parameter int XLEN     = 64,
    parameter int DEPTH    = 2,
    parameter int ALU_OPW  = 17,
    parameter int OP_SEL_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_flush,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [31:0]         i_insn,
    input  logic [XLEN-1:0]     i_pc,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [31:0]         o_insn,
    output logic [XLEN-1:0]     o_pc,
    output logic                o_rf_we,
    output logic [4:0]          o_rd,
    output logic [4:0]          o_rs1_addr,
    output logic [4:0]          o_rs2_addr,
    output logic                o_rs1_re,
    output logic                o_rs2_re,
    output logic [XLEN-1:0]     o_imm,
    output logic [OP_SEL_W-1:0] o_op_sel,
    output logic [ALU_OPW-1:0]  o_fu_sel,
    output logic                o_word,
    output logic                o_lsu_load,
    output logic                o_lsu_store,
    output logic                o_lsu_sigext,
    output logic [3:0]          o_lsu_size,
    output logic                o_illegal
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam bit RV64 = (XLEN == 64);

    localparam int OP_RF = 0, OP_IMM12_SEXT = 1, OP_IMM12_ZEXT = 2;
    localparam int OP_IMM13 = 3, OP_IMM20_SL12 = 4, OP_IMM21 = 5;

    localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLL = 2, ALU_SLT = 3, ALU_SLTU = 4;
    localparam int ALU_XOR = 5, ALU_SRL = 6, ALU_SRA = 7, ALU_OR = 8, ALU_AND = 9;
    localparam int ALU_BEQ = 10, ALU_BNE = 11, ALU_BLT = 12, ALU_BGE = 13;
    localparam int ALU_BLTU = 14, ALU_BGEU = 15, ALU_JAL = 16;

    typedef struct packed {
        logic [31:0]          insn;
        logic [XLEN-1:0]      pc;
        logic                 rf_we;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic                 rs1_re;
        logic                 rs2_re;
        logic [XLEN-1:0]      imm;
        logic [OP_SEL_W-1:0]  op_sel;
        logic [ALU_OPW-1:0]   fu_sel;
        logic                 word;
        logic                 load;
        logic                 store;
        logic                 sigext;
        logic [3:0]           size;
        logic                 illegal;
    } entry_t;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] immI, immS, immB, immJ, immU, imm32;
    logic        wrRd, useRs1, useRs2, illegal, word, load, store, sigext;
    logic [3:0]  size;
    logic [OP_SEL_W-1:0] opSel;
    logic [ALU_OPW-1:0]  fuSel;
    entry_t      dec;

    assign opcode = i_insn[6:0];
    assign funct3 = i_insn[14:12];
    assign funct7 = i_insn[31:25];
    assign immI = {{20{i_insn[31]}}, i_insn[31:20]};
    assign immS = {{20{i_insn[31]}}, i_insn[31:25], i_insn[11:7]};
    assign immB = {{19{i_insn[31]}}, i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0};
    assign immJ = {{11{i_insn[31]}}, i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0};
    assign immU = {i_insn[31:12], 12'b0};

    // Illegal encodings keep only the raw insn/pc so issue can raise the exception.
    always_comb begin
        wrRd = 1'b0; useRs1 = 1'b0; useRs2 = 1'b0; illegal = 1'b0;
        word = 1'b0; load = 1'b0; store = 1'b0; sigext = 1'b0;
        size = 4'd0; imm32 = '0; opSel = '0; fuSel = '0;
        case (opcode)
            7'b0110111, 7'b0010111: begin
                wrRd = 1'b1; imm32 = immU; opSel[OP_IMM20_SL12] = 1'b1; fuSel[ALU_ADD] = 1'b1;
            end
            7'b1101111: begin
                wrRd = 1'b1; imm32 = immJ; opSel[OP_IMM21] = 1'b1; fuSel[ALU_JAL] = 1'b1;
            end
            7'b1100111: begin
                wrRd = 1'b1; useRs1 = 1'b1; imm32 = immI; illegal = (funct3 != 3'b000);
                opSel[OP_IMM12_SEXT] = 1'b1; fuSel[ALU_JAL] = 1'b1;
            end
            7'b1100011: begin
                useRs1 = 1'b1; useRs2 = 1'b1; imm32 = immB; opSel[OP_IMM13] = 1'b1;
                case (funct3)
                    3'b000: fuSel[ALU_BEQ] = 1'b1;
                    3'b001: fuSel[ALU_BNE] = 1'b1;
                    3'b100: fuSel[ALU_BLT] = 1'b1;
                    3'b101: fuSel[ALU_BGE] = 1'b1;
                    3'b110: fuSel[ALU_BLTU] = 1'b1;
                    3'b111: fuSel[ALU_BGEU] = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            7'b0000011: begin
                wrRd = 1'b1; useRs1 = 1'b1; imm32 = immI; load = 1'b1;
                opSel[OP_IMM12_SEXT] = 1'b1; fuSel[ALU_ADD] = 1'b1;
                case (funct3)
                    3'b000: begin size = 4'd1; sigext = 1'b1; end
                    3'b001: begin size = 4'd2; sigext = 1'b1; end
                    3'b010: begin size = 4'd4; sigext = 1'b1; end
                    3'b011: begin size = 4'd8; illegal = !RV64; end
                    3'b100: size = 4'd1;
                    3'b101: size = 4'd2;
                    3'b110: begin size = 4'd4; illegal = !RV64; end
                    default: illegal = 1'b1;
                endcase
            end
            7'b0100011: begin
                useRs1 = 1'b1; useRs2 = 1'b1; imm32 = immS; store = 1'b1;
                opSel[OP_IMM12_SEXT] = 1'b1; fuSel[ALU_ADD] = 1'b1;
                case (funct3)
                    3'b000: size = 4'd1;
                    3'b001: size = 4'd2;
                    3'b010: size = 4'd4;
                    3'b011: begin size = 4'd8; illegal = !RV64; end
                    default: illegal = 1'b1;
                endcase
            end
            7'b0010011: begin
                wrRd = 1'b1; useRs1 = 1'b1; imm32 = immI;
                case (funct3)
                    3'b000: begin fuSel[ALU_ADD] = 1'b1; opSel[OP_IMM12_SEXT] = 1'b1; end
                    3'b010: begin fuSel[ALU_SLT] = 1'b1; opSel[OP_IMM12_SEXT] = 1'b1; end
                    3'b011: begin fuSel[ALU_SLTU] = 1'b1; opSel[OP_IMM12_SEXT] = 1'b1; end
                    3'b100: begin fuSel[ALU_XOR] = 1'b1; opSel[OP_IMM12_SEXT] = 1'b1; end
                    3'b110: begin fuSel[ALU_OR] = 1'b1; opSel[OP_IMM12_SEXT] = 1'b1; end
                    3'b111: begin fuSel[ALU_AND] = 1'b1; opSel[OP_IMM12_SEXT] = 1'b1; end
                    3'b001: begin
                        fuSel[ALU_SLL] = 1'b1; opSel[OP_IMM12_ZEXT] = 1'b1;
                        illegal = (i_insn[31:26] != 6'b0) || (!RV64 && i_insn[25]);
                    end
                    default: begin
                        fuSel[i_insn[30] ? ALU_SRA : ALU_SRL] = 1'b1; opSel[OP_IMM12_ZEXT] = 1'b1;
                        illegal = ({i_insn[31], i_insn[29:26]} != 5'b0) || (!RV64 && i_insn[25]);
                    end
                endcase
            end
            7'b0011011, 7'b0111011: begin
                // W-forms share one decode; bit 5 separates register from immediate form.
                wrRd = 1'b1; useRs1 = 1'b1; useRs2 = opcode[5]; word = 1'b1;
                imm32 = opcode[5] ? 32'b0 : immI;
                illegal = !RV64;
                if (funct3 == 3'b000 && !opcode[5]) begin
                    fuSel[ALU_ADD] = 1'b1; opSel[OP_IMM12_SEXT] = 1'b1;
                end else begin
                    opSel[opcode[5] ? OP_RF : OP_IMM12_ZEXT] = 1'b1;
                    case ({funct7, funct3})
                        10'b0000000_000: fuSel[ALU_ADD] = 1'b1;
                        10'b0100000_000: begin fuSel[ALU_SUB] = 1'b1; illegal = illegal | !opcode[5]; end
                        10'b0000000_001: fuSel[ALU_SLL] = 1'b1;
                        10'b0000000_101: fuSel[ALU_SRL] = 1'b1;
                        10'b0100000_101: fuSel[ALU_SRA] = 1'b1;
                        default: illegal = 1'b1;
                    endcase
                end
            end
            7'b0110011: begin
                wrRd = 1'b1; useRs1 = 1'b1; useRs2 = 1'b1; opSel[OP_RF] = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: fuSel[ALU_ADD] = 1'b1;
                    10'b0100000_000: fuSel[ALU_SUB] = 1'b1;
                    10'b0000000_001: fuSel[ALU_SLL] = 1'b1;
                    10'b0000000_010: fuSel[ALU_SLT] = 1'b1;
                    10'b0000000_011: fuSel[ALU_SLTU] = 1'b1;
                    10'b0000000_100: fuSel[ALU_XOR] = 1'b1;
                    10'b0000000_101: fuSel[ALU_SRL] = 1'b1;
                    10'b0100000_101: fuSel[ALU_SRA] = 1'b1;
                    10'b0000000_110: fuSel[ALU_OR] = 1'b1;
                    10'b0000000_111: fuSel[ALU_AND] = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            7'b0001111: illegal = (funct3 != 3'b000);
            7'b1110011: illegal = !((i_insn == 32'h0000_0073) || (i_insn == 32'h0010_0073));
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            wrRd = 1'b0; useRs1 = 1'b0; useRs2 = 1'b0; word = 1'b0; load = 1'b0;
            store = 1'b0; sigext = 1'b0; size = 4'd0; imm32 = '0; opSel = '0; fuSel = '0;
        end

        dec         = '0;
        dec.insn    = i_insn;
        dec.pc      = i_pc;
        dec.rf_we   = wrRd && (i_insn[11:7] != 5'd0);
        dec.rd      = wrRd ? i_insn[11:7] : 5'd0;
        dec.rs1     = useRs1 ? i_insn[19:15] : 5'd0;
        dec.rs2     = useRs2 ? i_insn[24:20] : 5'd0;
        dec.rs1_re  = useRs1;
        dec.rs2_re  = useRs2;
        dec.imm     = XLEN'($signed(imm32));
        dec.op_sel  = opSel;
        dec.fu_sel  = fuSel;
        dec.word    = word;
        dec.load    = load;
        dec.store   = store;
        dec.sigext  = sigext;
        dec.size    = size;
        dec.illegal = illegal;
    end

    entry_t          mem_q [DEPTH];
    entry_t          head;
    logic [PTRW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            ready_q, ready_d;
    logic            push, pop;

    assign push = i_valid & ready_q & ~i_flush;
    assign pop  = (count_q != '0) & i_ready;

    // Ready is registered from the next count, so a pop never raises it combinationally.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (i_flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) wrPtr_d = wrPtr_q + PTRW'(1);
            if (pop)  rdPtr_d = rdPtr_q + PTRW'(1);
            if (push && !pop)      count_d = count_q + CNTW'(1);
            else if (pop && !push) count_d = count_q - CNTW'(1);
        end
        ready_d = (count_d != CNTW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= dec;
    end

    assign head         = (count_q != '0) ? mem_q[rdPtr_q] : '0;
    assign o_ready      = ready_q;
    assign o_valid      = (count_q != '0);
    assign o_insn       = head.insn;
    assign o_pc         = head.pc;
    assign o_rf_we      = head.rf_we;
    assign o_rd         = head.rd;
    assign o_rs1_addr   = head.rs1;
    assign o_rs2_addr   = head.rs2;
    assign o_rs1_re     = head.rs1_re;
    assign o_rs2_re     = head.rs2_re;
    assign o_imm        = head.imm;
    assign o_op_sel     = head.op_sel;
    assign o_fu_sel     = head.fu_sel;
    assign o_word       = head.word;
    assign o_lsu_load   = head.load;
    assign o_lsu_store  = head.store;
    assign o_lsu_sigext = head.sigext;
    assign o_lsu_size   = head.size;
    assign o_illegal    = head.illegal;
endmodule
